// File: rtl/cc_block_gen_if.sv
// cc_block_gen_if: request/response bundle for the ChaCha block core.
// Signal names are written from the core's point of view (i_ = into the core, o_ = out of it).
// slave  : the block core itself.
// master : whoever issues requests and consumes keystream blocks.
interface cc_block_gen_if #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned NBLK_W = 8
);

    // Request side
    logic                  i_valid;
    logic                  o_ready;
    logic [255:0]          i_key;
    logic [127-CNT_W:0]    i_non;
    logic [CNT_W-1:0]      i_cnt;
    logic [NBLK_W-1:0]     i_nblk;

    // Keystream side
    logic                  o_valid;
    logic                  i_ready;
    logic [511:0]          o_stream;
    logic [CNT_W-1:0]      o_cnt;
    logic                  o_last;
    logic                  o_wrap;

    modport slave (
        input  i_valid,
        input  i_key,
        input  i_non,
        input  i_cnt,
        input  i_nblk,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_stream,
        output o_cnt,
        output o_last,
        output o_wrap
    );

    modport master (
        output i_valid,
        output i_key,
        output i_non,
        output i_cnt,
        output i_nblk,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_stream,
        input  o_cnt,
        input  o_last,
        input  o_wrap
    );

endinterface

// File: rtl/cc_block_gen.sv
// cc_block_gen: parametrised ChaCha block-function core.
// A request latches key, nonce and counter and asks for a run of i_nblk blocks (0 means 1).
// Each block takes ROUNDS rounds at four cycles per round (one quarter-round step per cycle,
// all four quarter-rounds in parallel), one cycle to add the initial state back, then sits in
// OUT until the consumer takes it. Between blocks of a run the counter increments mod 2^CNT_W.
// ROUNDS must be even and >= 2; CNT_W must be 32 or 64.
// Optional feature macro: CC_ZEROIZE_EN -- on the final handshake of a run, state, key, nonce
// and counter registers are wiped so nothing secret lingers (o_stream then reads 0 in IDLE).
module cc_block_gen #(
    parameter int unsigned ROUNDS = 20,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned NBLK_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    cc_block_gen_if.slave     io_cc
);

    localparam int unsigned RND_W = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRnd,
        StAdd,
        StOut
    } fsm_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    function automatic logic [31:0] f_rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // State index of row 'row' for quarter-round 'q'; diagonals shift column by row.
    function automatic logic [3:0] f_idx(input int unsigned row, input int unsigned q,
                                         input logic diag);
        logic [1:0] col;
        col = 2'(q) + (diag ? 2'(row) : 2'd0);
        return {2'(row), col};
    endfunction

    // Initial ChaCha state: constants, key, then counter words followed by nonce words.
    function automatic logic [15:0][31:0] f_init(input logic [255:0]       key,
                                                 input logic [127-CNT_W:0] non,
                                                 input logic [CNT_W-1:0]   cnt);
        logic [15:0][31:0] s;
        logic [127:0]      tail;
        s[0] = 32'h61707865;
        s[1] = 32'h3320646e;
        s[2] = 32'h79622d32;
        s[3] = 32'h6b206574;
        for (int k = 0; k < 8; k++) begin
            s[4+k] = key[32*k +: 32];
        end
        tail = {non, cnt};
        for (int k = 0; k < 4; k++) begin
            s[12+k] = tail[32*k +: 32];
        end
        return s;
    endfunction

    // One chained step of the quarter-round, applied to all four quarter-rounds at once.
    // The four quarter-rounds touch disjoint words, so order within the loop is irrelevant.
    function automatic logic [15:0][31:0] f_step(input logic [15:0][31:0] s,
                                                 input logic [1:0]        step,
                                                 input logic              diag);
        logic [15:0][31:0] r;
        logic [3:0]        ia, ib, ic, id;
        logic [31:0]       sum;
        r = s;
        for (int q = 0; q < 4; q++) begin
            ia = f_idx(0, q, diag);
            ib = f_idx(1, q, diag);
            ic = f_idx(2, q, diag);
            id = f_idx(3, q, diag);
            case (step)
                2'd0: begin
                    sum   = r[ia] + r[ib];
                    r[ia] = sum;
                    r[id] = f_rotl(r[id] ^ sum, 16);
                end
                2'd1: begin
                    sum   = r[ic] + r[id];
                    r[ic] = sum;
                    r[ib] = f_rotl(r[ib] ^ sum, 12);
                end
                2'd2: begin
                    sum   = r[ia] + r[ib];
                    r[ia] = sum;
                    r[id] = f_rotl(r[id] ^ sum, 8);
                end
                default: begin
                    sum   = r[ic] + r[id];
                    r[ic] = sum;
                    r[ib] = f_rotl(r[ib] ^ sum, 7);
                end
            endcase
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------

    fsm_e                 r_fsm;
    fsm_e                 w_fsm_nxt;

    logic [15:0][31:0]    r_state;
    logic [255:0]         r_key;
    logic [127-CNT_W:0]   r_non;
    logic [CNT_W-1:0]     r_cnt;
    logic [NBLK_W-1:0]    r_rem;
    logic [RND_W-1:0]     r_rnd;
    logic [1:0]           r_step;
    logic                 r_wrap;

    logic [15:0][31:0]    w_init;
    logic [15:0][31:0]    w_reload;
    logic [15:0][31:0]    w_step_state;
    logic [15:0][31:0]    w_add_state;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 w_rnd_done;
    logic                 w_ready;
    logic                 w_valid;
    logic                 w_accept;
    logic                 w_step_en;
    logic                 w_add_en;
    logic                 w_chain;
    logic                 w_finish;

    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_init       = f_init(r_key, r_non, r_cnt);
    assign w_reload     = f_init(r_key, r_non, w_cnt_inc);
    assign w_step_state = f_step(r_state, r_step, r_rnd[0]);
    assign w_rnd_done   = (r_rnd == RND_W'(ROUNDS - 1)) && (r_step == 2'd3);

    // Feed-forward: working state plus the initial state of the current counter.
    always_comb begin
        w_add_state = '0;
        for (int k = 0; k < 16; k++) begin
            w_add_state[k] = r_state[k] + w_init[k];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_fsm <= StIdle;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_ready   = 1'b0;
        w_valid   = 1'b0;
        w_accept  = 1'b0;
        w_step_en = 1'b0;
        w_add_en  = 1'b0;
        w_chain   = 1'b0;
        w_finish  = 1'b0;
        unique case (r_fsm)
            StIdle: begin
                w_ready = 1'b1;
                if (io_cc.i_valid) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = StRnd;
                end
            end
            StRnd: begin
                w_step_en = 1'b1;
                if (w_rnd_done) begin
                    w_fsm_nxt = StAdd;
                end
            end
            StAdd: begin
                w_add_en  = 1'b1;
                w_fsm_nxt = StOut;
            end
            StOut: begin
                w_valid = 1'b1;
                if (io_cc.i_ready) begin
                    if (r_rem > NBLK_W'(1)) begin
                        w_chain   = 1'b1;
                        w_fsm_nxt = StRnd;
                    end else begin
                        w_finish  = 1'b1;
                        w_fsm_nxt = StIdle;
                    end
                end
            end
            default: begin
                w_fsm_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Working state, latched request fields, run bookkeeping.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= '0;
            r_key   <= '0;
            r_non   <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_rnd   <= '0;
            r_step  <= '0;
            r_wrap  <= 1'b0;
        end else if (w_accept) begin
            r_key   <= io_cc.i_key;
            r_non   <= io_cc.i_non;
            r_cnt   <= io_cc.i_cnt;
            r_rem   <= (io_cc.i_nblk == '0) ? NBLK_W'(1) : io_cc.i_nblk;
            r_state <= f_init(io_cc.i_key, io_cc.i_non, io_cc.i_cnt);
            r_rnd   <= '0;
            r_step  <= '0;
            // The first block of a run never reports a wrap.
            r_wrap  <= 1'b0;
        end else if (w_step_en) begin
            r_state <= w_step_state;
            r_step  <= r_step + 2'd1;
            if (r_step == 2'd3) begin
                r_rnd <= r_rnd + RND_W'(1);
            end
        end else if (w_add_en) begin
            r_state <= w_add_state;
        end else if (w_chain) begin
            r_cnt   <= w_cnt_inc;
            r_rem   <= r_rem - NBLK_W'(1);
            r_state <= w_reload;
            r_rnd   <= '0;
            r_step  <= '0;
            r_wrap  <= (w_cnt_inc == '0);
        end else if (w_finish) begin
`ifdef CC_ZEROIZE_EN
            r_state <= '0;
            r_key   <= '0;
            r_non   <= '0;
            r_cnt   <= '0;
`endif
            r_rem   <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign io_cc.o_ready  = w_ready;
    assign io_cc.o_valid  = w_valid;
    assign io_cc.o_stream = r_state;
    assign io_cc.o_cnt    = r_cnt;
    assign io_cc.o_last   = w_valid && (r_rem == NBLK_W'(1));
    assign io_cc.o_wrap   = w_valid && r_wrap;

endmodule

// File: tb/tb_cc_block_gen.sv
// tb_cc_block_gen: directed bench for the ChaCha block core.
// Two instances: ROUNDS=20 (RFC 8439 vector, backpressure, counter wrap, reset abort) and
// ROUNDS=8 (zero-length run, request while busy). Blocks other than the RFC vector are
// checked against a plain textbook ChaCha model.
module tb_cc_block_gen;

    localparam logic [255:0] RFC_KEY = {
        32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
        32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100
    };
    localparam logic [95:0]  RFC_NON = {32'h00000000, 32'h4a000000, 32'h09000000};
    localparam logic [511:0] RFC_BLK = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110
    };
    localparam logic [255:0] KEY8 = 256'h8899aabb_ccddeeff_00112233_44556677_deadbeef_cafef00d_01234567_89abcdef;
    localparam logic [95:0]  NON8 = 96'h13572468_9abcdef0_0f1e2d3c;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    cc_block_gen_if #(.CNT_W(32), .NBLK_W(8)) bus20 ();
    cc_block_gen_if #(.CNT_W(32), .NBLK_W(8)) bus8 ();

    cc_block_gen #(.ROUNDS(20), .CNT_W(32), .NBLK_W(8)) u_dut20 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_cc  (bus20)
    );

    cc_block_gen #(.ROUNDS(8), .CNT_W(32), .NBLK_W(8)) u_dut8 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io_cc  (bus8)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [15:0][31:0] ref_qr(input logic [15:0][31:0] s,
                                                 input int a, input int b, input int c, input int d);
        logic [15:0][31:0] x;
        x = s;
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
        return x;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] key, input logic [95:0] non,
                                               input logic [31:0] cnt, input int rounds);
        logic [15:0][31:0] x, x0;
        x[0] = 32'h61707865; x[1] = 32'h3320646e; x[2] = 32'h79622d32; x[3] = 32'h6b206574;
        for (int k = 0; k < 8; k++) x[4+k] = key[32*k +: 32];
        x[12] = cnt;
        for (int k = 0; k < 3; k++) x[13+k] = non[32*k +: 32];
        x0 = x;
        for (int r = 0; r < rounds; r += 2) begin
            x = ref_qr(x, 0, 4, 8, 12); x = ref_qr(x, 1, 5, 9, 13);
            x = ref_qr(x, 2, 6, 10, 14); x = ref_qr(x, 3, 7, 11, 15);
            x = ref_qr(x, 0, 5, 10, 15); x = ref_qr(x, 1, 6, 11, 12);
            x = ref_qr(x, 2, 7, 8, 13); x = ref_qr(x, 3, 4, 9, 14);
        end
        for (int k = 0; k < 16; k++) x[k] = x[k] + x0[k];
        return x;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges since the accept/handshake edge (that edge counts as 1).
    task automatic wait_valid(input bit s8, input int lat0, output int lat);
        lat = lat0;
        while (((s8 ? bus8.o_valid : bus20.o_valid) !== 1'b1) && lat < 400) begin
            step();
            lat++;
        end
    endtask

    task automatic start20(input logic [255:0] key, input logic [95:0] non,
                           input logic [31:0] cnt, input logic [7:0] nblk);
        chk("req20_ready", bus20.o_ready, 1'b1);
        bus20.i_key = key; bus20.i_non = non; bus20.i_cnt = cnt; bus20.i_nblk = nblk;
        bus20.i_valid = 1'b1;
        step();
        bus20.i_valid = 1'b0;
    endtask

    task automatic start8(input logic [255:0] key, input logic [95:0] non,
                          input logic [31:0] cnt, input logic [7:0] nblk);
        chk("req8_ready", bus8.o_ready, 1'b1);
        bus8.i_key = key; bus8.i_non = non; bus8.i_cnt = cnt; bus8.i_nblk = nblk;
        bus8.i_valid = 1'b1;
        step();
        bus8.i_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp_idle;
        logic [31:0]  cnt_exp;
        logic         seen;
        int           lat;

`ifdef CC_ZEROIZE_EN
        exp_idle = '0;
`else
        exp_idle = RFC_BLK;
`endif
        bus20.i_valid = 1'b0; bus20.i_ready = 1'b0; bus20.i_key = '0;
        bus20.i_non = '0; bus20.i_cnt = '0; bus20.i_nblk = '0;
        bus8.i_valid = 1'b0; bus8.i_ready = 1'b0; bus8.i_key = '0;
        bus8.i_non = '0; bus8.i_cnt = '0; bus8.i_nblk = '0;

        // Reset state
        step(); step();
        chk("rst_valid", bus20.o_valid, 1'b0);
        chk("rst_stream", bus20.o_stream, '0);
        chk("rst_cnt", bus20.o_cnt, '0);
        chk("rst_last", bus20.o_last, 1'b0);
        chk("rst_wrap", bus20.o_wrap, 1'b0);
        rstn = 1'b1;
        step();
        chk("rst_ready20", bus20.o_ready, 1'b1);
        chk("rst_ready8", bus8.o_ready, 1'b1);

        // RFC 8439 2.3.2 block, then 10 cycles of backpressure
        start20(RFC_KEY, RFC_NON, 32'd1, 8'd1);
        wait_valid(1'b0, 1, lat);
        chk("t1_latency", lat, 82);
        chk("t1_stream", bus20.o_stream, RFC_BLK);
        chk("t1_cnt", bus20.o_cnt, 32'd1);
        chk("t1_last", bus20.o_last, 1'b1);
        chk("t1_wrap", bus20.o_wrap, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_hold_valid", bus20.o_valid, 1'b1);
            chk("t2_hold_stream", bus20.o_stream, RFC_BLK);
            chk("t2_hold_ready", bus20.o_ready, 1'b0);
        end
        bus20.i_ready = 1'b1;
        step();
        bus20.i_ready = 1'b0;
        chk("t2_release_valid", bus20.o_valid, 1'b0);
        chk("t2_idle_ready", bus20.o_ready, 1'b1);
        chk("t6_idle_stream_a", bus20.o_stream, exp_idle);

        // Three-block run across the counter wrap; i_ready held high throughout
        bus20.i_ready = 1'b1;
        start20(RFC_KEY, RFC_NON, 32'hffffffff, 8'd3);
        for (int b = 0; b < 3; b++) begin
            cnt_exp = 32'hffffffff + 32'(b);
            wait_valid(1'b0, 1, lat);
            chk("t3_gap", lat, 82);
            chk("t3_cnt", bus20.o_cnt, cnt_exp);
            chk("t3_wrap", bus20.o_wrap, (b == 1));
            chk("t3_last", bus20.o_last, (b == 2));
            chk("t3_stream", bus20.o_stream, ref_block(RFC_KEY, RFC_NON, cnt_exp, 20));
            step();
        end
        bus20.i_ready = 1'b0;
        chk("t3_done_valid", bus20.o_valid, 1'b0);
        chk("t3_done_ready", bus20.o_ready, 1'b1);

        // ROUNDS=8, i_nblk=0, stray request while busy
        start8(KEY8, NON8, 32'd5, 8'd0);
        repeat (5) step();
        bus8.i_valid = 1'b1; bus8.i_key = ~KEY8; bus8.i_cnt = 32'd99; bus8.i_nblk = 8'd4;
        chk("t4_busy_ready", bus8.o_ready, 1'b0);
        step();
        bus8.i_valid = 1'b0;
        wait_valid(1'b1, 7, lat);
        chk("t4_latency", lat, 34);
        chk("t4_stream", bus8.o_stream, ref_block(KEY8, NON8, 32'd5, 8));
        chk("t4_cnt", bus8.o_cnt, 32'd5);
        chk("t4_last", bus8.o_last, 1'b1);
        bus8.i_ready = 1'b1;
        step();
        bus8.i_ready = 1'b0;
        chk("t4_done_valid", bus8.o_valid, 1'b0);
        seen = 1'b0;
        repeat (50) begin
            step();
            if (bus8.o_valid) seen = 1'b1;
        end
        chk("t4_single_block", seen, 1'b0);

        // Reset in the middle of RND
        start20(RFC_KEY, RFC_NON, 32'd1, 8'd1);
        repeat (39) step();
        chk("t5_busy_ready", bus20.o_ready, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t5_valid", bus20.o_valid, 1'b0);
        chk("t5_stream", bus20.o_stream, '0);
        chk("t5_cnt", bus20.o_cnt, '0);
        chk("t5_last", bus20.o_last, 1'b0);
        chk("t5_wrap", bus20.o_wrap, 1'b0);
        step(); step();
        rstn = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            step();
            if (bus20.o_valid) seen = 1'b1;
        end
        chk("t5_no_emit", seen, 1'b0);
        start20(RFC_KEY, RFC_NON, 32'd1, 8'd1);
        wait_valid(1'b0, 1, lat);
        chk("t5_latency", lat, 82);
        chk("t5_stream_after", bus20.o_stream, RFC_BLK);
        chk("t5_last_after", bus20.o_last, 1'b1);
        bus20.i_ready = 1'b1;
        step();
        bus20.i_ready = 1'b0;
        chk("t6_idle_stream_b", bus20.o_stream, exp_idle);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
